// File: rtl/bus_timer_target.sv
// CPU external-bus target: 256-byte window with wait states, holding a prescaled 32-bit timer.
// Optional BUS_TIMER_CAPTURE_EN adds an i_capture input and a CAPTURE register at offset 0x14.
module bus_timer_target #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                  i_cpu_clk,
    input  logic                  i_rst,
    input  logic                  i_bus_clk,
    input  logic                  i_bus_we,
    input  logic [31:0]           i_bus_addr,
    input  logic [DATA_WIDTH-1:0] i_bus_data,
`ifdef BUS_TIMER_CAPTURE_EN
    input  logic                  i_capture,
`endif
    output logic [DATA_WIDTH-1:0] o_bus_data,
    output logic                  o_bus_data_ready,
    output logic                  o_irq
);

    localparam logic [7:0] OffCtrl    = 8'h00;
    localparam logic [7:0] OffCount   = 8'h04;
    localparam logic [7:0] OffCompare = 8'h08;
    localparam logic [7:0] OffStatus  = 8'h0C;
    localparam logic [7:0] OffPresc   = 8'h10;
    localparam logic [7:0] OffCapture = 8'h14;

    typedef enum logic [1:0] {StIdle, StWait, StResp, StHold} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              wait_q, wait_d;
    logic                    ready_q, ready_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [2:0]              ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]   compare_q, compare_d;
    logic [DATA_WIDTH-1:0]   presc_q, presc_d;
    logic [DATA_WIDTH-1:0]   presc_cnt_q, presc_cnt_d;
    logic                    match_q, match_d;
    logic                    irq_q, irq_d;

    logic                    hit;
    logic                    bus_wr;
    logic [7:0]              offset;
    logic [DATA_WIDTH-1:0]   reg_rdata;
    logic                    wr_ctrl, wr_count, wr_compare, wr_status, wr_presc;
    logic                    tick;
    logic                    match_set;
    logic                    capf;
    logic [DATA_WIDTH-1:0]   capture_val;

    assign hit    = (i_bus_addr[31:8] == BASE_ADDR[31:8]);
    assign offset = i_bus_addr[7:0];

    // Bus handshake
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ready_d = ready_q;
        rdata_d = rdata_q;
        bus_wr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_bus_clk && hit) begin
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        wait_d  = 4'(WAIT_STATES);
                    end
                end
            end
            StWait: begin
                wait_d = wait_q - 4'd1;
                if (!i_bus_clk) begin
                    state_d = StIdle;
                end else if (wait_q <= 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                bus_wr  = i_bus_we;
                rdata_d = i_bus_we ? '0 : reg_rdata;
                ready_d = 1'b1;
                state_d = StHold;
            end
            StHold: begin
                if (!i_bus_clk) begin
                    ready_d = 1'b0;
                    rdata_d = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        reg_rdata = '0;
        case (offset)
            OffCtrl:    reg_rdata = {{(DATA_WIDTH-3){1'b0}}, ctrl_q};
            OffCount:   reg_rdata = count_q;
            OffCompare: reg_rdata = compare_q;
            OffStatus:  reg_rdata = {{(DATA_WIDTH-2){1'b0}}, capf, match_q};
            OffPresc:   reg_rdata = presc_q;
            OffCapture: reg_rdata = capture_val;
            default:    reg_rdata = '0;
        endcase
    end

    assign wr_ctrl    = bus_wr && (offset == OffCtrl);
    assign wr_count   = bus_wr && (offset == OffCount);
    assign wr_compare = bus_wr && (offset == OffCompare);
    assign wr_status  = bus_wr && (offset == OffStatus);
    assign wr_presc   = bus_wr && (offset == OffPresc);

    assign tick = ctrl_q[0] && (presc_cnt_q == presc_q);

    // Timer; a bus write to COUNT overrides the tick and suppresses match evaluation
    always_comb begin
        ctrl_d      = wr_ctrl ? i_bus_data[2:0] : ctrl_q;
        compare_d   = wr_compare ? i_bus_data : compare_q;
        presc_d     = wr_presc ? i_bus_data : presc_q;
        count_d     = count_q;
        match_set   = 1'b0;
        presc_cnt_d = presc_cnt_q;

        if (wr_ctrl || wr_presc) begin
            presc_cnt_d = '0;
        end else if (ctrl_q[0]) begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        end

        if (wr_count) begin
            count_d = i_bus_data;
        end else if (tick) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                count_d   = ctrl_q[1] ? '0 : count_q + 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        match_d = match_set | (match_q & ~(wr_status & i_bus_data[0]));
        irq_d   = match_q & ctrl_q[2];
    end

    always_ff @(posedge i_cpu_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            ctrl_q      <= '0;
            count_q     <= '0;
            compare_q   <= '1;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            match_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            ctrl_q      <= ctrl_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            match_q     <= match_d;
            irq_q       <= irq_d;
        end
    end

`ifdef BUS_TIMER_CAPTURE_EN
    // [0],[1] synchronise; [2] is the prior synchronised sample for edge detection
    logic [2:0]            cap_sync_q;
    logic                  cap_edge;
    logic                  capf_q, capf_d;
    logic [DATA_WIDTH-1:0] capture_q;

    assign cap_edge = cap_sync_q[1] & ~cap_sync_q[2];
    assign capf_d   = cap_edge | (capf_q & ~(wr_status & i_bus_data[1]));

    always_ff @(posedge i_cpu_clk) begin
        if (i_rst) begin
            cap_sync_q <= '0;
            capf_q     <= 1'b0;
            capture_q  <= '0;
        end else begin
            cap_sync_q <= {cap_sync_q[1:0], i_capture};
            capf_q     <= capf_d;
            if (cap_edge) begin
                capture_q <= count_q;
            end
        end
    end

    assign capf        = capf_q;
    assign capture_val = capture_q;
`else
    assign capf        = 1'b0;
    assign capture_val = '0;
`endif

    assign o_bus_data       = rdata_q;
    assign o_bus_data_ready = ready_q;
    assign o_irq            = irq_q;

endmodule

// File: tb/tb_bus_timer_target.sv
// Bench for bus_timer_target (WAIT_STATES=2): directed steps plus random register traffic checked
// against a spec-level register/timer model. Exercises i_capture when BUS_TIMER_CAPTURE_EN is set.
module tb_bus_timer_target;

    localparam logic [31:0] Base = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_clk;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rdy;
    logic        irq;
    logic        capture;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bus_timer_target #(
        .BASE_ADDR   (Base),
        .WAIT_STATES (2),
        .DATA_WIDTH  (32)
    ) dut (
        .i_cpu_clk        (clk),
        .i_rst            (rst),
        .i_bus_clk        (bus_clk),
        .i_bus_we         (bus_we),
        .i_bus_addr       (bus_addr),
        .i_bus_data       (bus_wdata),
`ifdef BUS_TIMER_CAPTURE_EN
        .i_capture        (capture),
`endif
        .o_bus_data       (bus_rdata),
        .o_bus_data_ready (bus_rdy),
        .o_irq            (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: register contents after edge number m_last
    logic [31:0] m_ctrl, m_count, m_compare, m_presc, m_pc, m_capture;
    logic        m_match, m_capf, m_irq;
    int          m_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_count = 0; m_compare = 32'hFFFF_FFFF; m_presc = 0; m_pc = 0;
        m_capture = 0; m_match = 0; m_capf = 0; m_irq = 0;
        m_last = cyc;
    endtask

    task automatic model_step(input bit wr, input logic [7:0] off, input logic [31:0] wd);
        logic        en, tk, new_irq, hit_match;
        logic [31:0] nxt;
        en        = m_ctrl[0];
        tk        = en && (m_pc == m_presc);
        new_irq   = m_match & m_ctrl[2];
        hit_match = 1'b0;
        nxt       = m_count;
        if (wr && off == 8'h04) nxt = wd;
        else if (tk) begin
            if (m_count == m_compare) begin
                hit_match = 1'b1;
                nxt = m_ctrl[1] ? 32'd0 : m_count + 32'd1;
            end else nxt = m_count + 32'd1;
        end
        if (wr && (off == 8'h00 || off == 8'h10)) m_pc = 0;
        else if (tk) m_pc = 0;
        else if (en) m_pc = m_pc + 1;
        m_match = hit_match | (m_match & !(wr && off == 8'h0C && wd[0]));
        m_capf  = m_capf & !(wr && off == 8'h0C && wd[1]);
        if (wr && off == 8'h00) m_ctrl = {29'd0, wd[2:0]};
        if (wr && off == 8'h08) m_compare = wd;
        if (wr && off == 8'h10) m_presc = wd;
        m_count = nxt;
        m_irq   = new_irq;
        m_last++;
    endtask

    task automatic model_sync(input int upto);
        while (m_last < upto) model_step(1'b0, 8'h00, 32'd0);
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off);
        case (off)
            8'h00:   return m_ctrl;
            8'h04:   return m_count;
            8'h08:   return m_compare;
            8'h0C:   return {30'd0, m_capf, m_match};
            8'h10:   return m_presc;
`ifdef BUS_TIMER_CAPTURE_EN
            8'h14:   return m_capture;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full handshake; called just after a rising edge. commit = edge at which ready rose.
    task automatic bus_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              input int extra, output logic [31:0] rd, output int commit);
        int n;
        bit hold_ok;
        n = 0;
        bus_clk = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
        for (int i = 1; i <= 12 && n == 0; i++) begin
            @(posedge clk);
            #1;
            if (bus_rdy) n = i;
        end
        check("latency", n, 4);
        commit  = cyc;
        rd      = bus_rdata;
        hold_ok = 1'b1;
        for (int k = 0; k < extra; k++) begin
            @(posedge clk);
            #1;
            if (!bus_rdy || bus_rdata !== rd) hold_ok = 1'b0;
        end
        if (extra > 0) check("hold_stable", {31'd0, hold_ok}, 32'd1);
        bus_clk = 1'b0;
        @(posedge clk);
        #1;
        check("release", {bus_rdata[30:0], bus_rdy}, 32'd0);
    endtask

    task automatic reg_write_x(input logic [7:0] off, input logic [31:0] wd, input int extra,
                               output int commit);
        logic [31:0] rd;
        bus_access(1'b1, Base | {24'd0, off}, wd, extra, rd, commit);
        model_sync(commit - 1);
        model_step(1'b1, off, wd);
    endtask

    task automatic reg_write(input logic [7:0] off, input logic [31:0] wd);
        int c;
        reg_write_x(off, wd, 0, c);
    endtask

    task automatic reg_read(input logic [7:0] off, input string tag, output logic [31:0] rd);
        int c;
        bus_access(1'b0, Base | {24'd0, off}, 32'd0, 0, rd, c);
        model_sync(c - 1);
        check(tag, rd, model_read(off));
    endtask

    task automatic check_irq(input string tag);
        model_sync(cyc);
        check(tag, {31'd0, irq}, {31'd0, m_irq});
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  offs [8];
        logic [7:0]  off;
        logic [31:0] wd;
        int          ce, n;

        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h05, 8'h40};
        rst = 1'b1; bus_clk = 1'b0; bus_we = 1'b0; bus_addr = 0; bus_wdata = 0; capture = 1'b0;
        idle(3);
        check("reset_outputs", {bus_rdata[29:0], bus_rdy, irq}, 32'd0);
        rst = 1'b0;
        model_reset();

        // Reset values and read latency
        reg_read(8'h08, "reset_compare", rd);
        check("reset_compare_const", rd, 32'hFFFF_FFFF);
        reg_read(8'h00, "reset_ctrl", rd);
        reg_read(8'h04, "reset_count", rd);
        reg_read(8'h0C, "reset_status", rd);
        reg_read(8'h10, "reset_presc", rd);

        // Write held for 5 extra cycles, then read back
        reg_write_x(8'h04, 32'h1234, 5, ce);
        reg_read(8'h04, "count_rb", rd);
        check("count_rb_const", rd, 32'h1234);

        // Prescaled count to compare with auto-reload and IRQ
        reg_write(8'h10, 32'd3);
        reg_write(8'h08, 32'd5);
        reg_write(8'h04, 32'd0);
        reg_write(8'h00, 32'd7);
        idle(30);
        check_irq("irq_after_match");
        check("irq_set", {31'd0, irq}, 32'd1);
        reg_read(8'h0C, "status_match", rd);
        check("status_match_const", rd, 32'd1);
        reg_read(8'h04, "count_reload", rd);

        // W1C clears MATCH and IRQ
        reg_write(8'h00, 32'd4);
        reg_write(8'h0C, 32'd1);
        idle(1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        reg_read(8'h0C, "status_cleared", rd);

        // W1C landing on the same edge as a new match: set wins
        reg_write(8'h00, 32'd0);
        reg_write(8'h10, 32'd0);
        reg_write(8'h08, 32'd1000);
        reg_write(8'h04, 32'd990);
        reg_write_x(8'h00, 32'd1, 0, ce);
        while (cyc < ce + 7) idle(1);
        reg_write(8'h0C, 32'd1);
        reg_read(8'h0C, "w1c_vs_match", rd);
        check("w1c_vs_match_const", rd, 32'd1);
        reg_write(8'h00, 32'd0);
        reg_write(8'h0C, 32'd1);

        // Outside the window: never ready
        bus_clk = 1'b1; bus_we = 1'b0; bus_addr = 32'h0002_0000;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (bus_rdy) n++;
        end
        check("miss_no_ready", n, 0);
        bus_clk = 1'b0;
        idle(1);

        // Strobe dropped during WAIT: no ready, no write
        bus_clk = 1'b1; bus_we = 1'b1; bus_addr = Base | 32'h04; bus_wdata = 32'hDEAD_BEEF;
        idle(2);
        bus_clk = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (bus_rdy) n++;
        end
        check("abort_no_ready", n, 0);
        reg_read(8'h04, "abort_no_write", rd);

        // Reset while holding ready: ready drops on the next edge
        bus_clk = 1'b1; bus_we = 1'b0; bus_addr = Base | 32'h08;
        idle(4);
        check("pre_reset_ready", {31'd0, bus_rdy}, 32'd1);
        rst = 1'b1;
        idle(1);
        check("reset_drops_ready", {bus_rdata[30:0], bus_rdy}, 32'd0);
        rst = 1'b0; bus_clk = 1'b0;
        model_reset();

        // Reset while a write is still waiting: write discarded
        bus_clk = 1'b1; bus_we = 1'b1; bus_addr = Base | 32'h04; bus_wdata = 32'h5555;
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0; bus_clk = 1'b0;
        model_reset();
        reg_read(8'h04, "reset_discard", rd);
        check("reset_discard_const", rd, 32'd0);

        // Random register traffic
        for (int i = 0; i < 40; i++) begin
            off = offs[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 1) begin
                model_sync(cyc);
                case (off)
                    8'h00:   wd = $urandom_range(0, 7);
                    8'h04:   wd = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                                              : $urandom;
                    8'h08:   wd = m_count + $urandom_range(0, 12);
                    8'h10:   wd = $urandom_range(0, 4);
                    default: wd = $urandom;
                endcase
                reg_write(off, wd);
            end else begin
                reg_read(off, "rand_read", rd);
            end
            idle($urandom_range(0, 5));
            check_irq("rand_irq");
        end

`ifdef BUS_TIMER_CAPTURE_EN
        reg_write(8'h00, 32'd0);
        reg_write(8'h04, 32'd100);
        reg_write(8'h0C, 32'd3);
        capture = 1'b1;
        idle(2);
        capture = 1'b0;
        idle(4);
        model_sync(cyc);
        m_capture = 32'd100;
        m_capf    = 1'b1;
        reg_read(8'h14, "capture_val", rd);
        check("capture_val_const", rd, 32'd100);
        reg_read(8'h0C, "capture_flag", rd);
        check("capture_flag_const", rd, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
